dma_mem_responder: RTL

//  Responder end of the DMA req/grant/indata bus: arbitrates N_REQ requesters and returns memory read data.

---
 rtl/dma_pkg.sv | 14 +
 rtl/dma_mem_responder_rr_arbiter.sv | 24 ++
 rtl/dma_mem_responder.sv | 116 +++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared types and widths for the DMA memory responder.
// Holds default bus widths and the responder FSM state encoding.
package dma_pkg;

    localparam int DMA_ADDR_W = 14;
    localparam int DMA_DATA_W = 10;

    typedef enum logic [1:0] {
        RESP_IDLE  = 2'd0,
        RESP_GRANT = 2'd1,
        RESP_DATA  = 2'd2
    } resp_state_t;

endpackage

// File: rtl/dma_mem_responder_rr_arbiter.sv
// Combinational round-robin arbiter: first eligible requester
// at or after the pointer wins.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] elig_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] win_o,
    output logic             valid_o
);

    always_comb begin
        win_o   = '0;
        valid_o = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!valid_o && elig_i[(int'(ptr_i) + k) % N_REQ]) begin
                win_o[(int'(ptr_i) + k) % N_REQ] = 1'b1;
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dma_mem_responder.sv
// Responder end of the DMA req/grant/indata bus with a host-loaded memory.
// Optional per-requester grant counters: define DMA_RESP_STATS_EN.
module dma_mem_responder
    import dma_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int ADDR_W = DMA_ADDR_W,
    parameter int DATA_W = DMA_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*ADDR_W-1:0] addr,
    output logic [N_REQ-1:0]        grant,
    output logic [DATA_W-1:0]       rdata,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
`ifdef DMA_RESP_STATS_EN
    input  logic [$clog2(N_REQ)-1:0] D_SEL,
    output logic [15:0]             D_COUNT,
`endif
    output logic [1:0]              D_STATE
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int DEPTH = 1 << ADDR_W;

    resp_state_t        state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_qq;
    logic [N_REQ-1:0]   elig, win;
    logic               valid;
    logic [PTR_W-1:0]   ptr_q, ptr_d, win_idx;
    logic [ADDR_W-1:0]  rd_addr_q;
    logic [DATA_W-1:0]  rdata_q;
    logic [DATA_W-1:0]  mem [DEPTH];

    // A requester stays masked through its grant and data cycles.
    assign elig = req & ~grant_q & ~grant_qq;

    rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
        .elig_i  (elig),
        .ptr_i   (ptr_q),
        .win_o   (win),
        .valid_o (valid)
    );

    always_comb begin
        win_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) win_idx = PTR_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (valid) begin
            state_d = RESP_GRANT;
            ptr_d   = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
        end else begin
            unique case (state_q)
                RESP_IDLE:  state_d = RESP_IDLE;
                RESP_GRANT: state_d = RESP_DATA;
                RESP_DATA:  state_d = RESP_IDLE;
                default:    state_d = RESP_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= RESP_IDLE;
            grant_q  <= '0;
            grant_qq <= '0;
            ptr_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= win;
            grant_qq <= grant_q;
            ptr_q    <= ptr_d;
            if (|grant_q) rdata_q <= mem[rd_addr_q];
        end
    end

    always_ff @(posedge clk) begin
        if (valid) rd_addr_q <= addr[int'(win_idx)*ADDR_W +: ADDR_W];
    end

    // Write lands at the same edge as any read: readers see the old word.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

`ifdef DMA_RESP_STATS_EN
    logic [15:0] cnt_q [N_REQ];

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (!rst) begin
                cnt_q[i] <= '0;
            end else if (grant_q[i] && cnt_q[i] != 16'hFFFF) begin
                cnt_q[i] <= cnt_q[i] + 16'd1;
            end
        end
    end

    assign D_COUNT = cnt_q[D_SEL];
`endif

    assign grant   = grant_q;
    assign rdata   = rdata_q;
    assign D_STATE = state_q;

endmodule
